// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb3lite_interconnect_slave_arbiter
// Function : per-slave address/data-phase arbiter, priority + round-robin ties
// Revision : 1.0
// ============================================================================
module ahb3lite_interconnect_slave_arbiter #(
    parameter  int MASTERS       = 3,
    localparam int PRIORITY_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS),
    localparam int ID_BITS       = (MASTERS == 1) ? 1 : $clog2(MASTERS)
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [MASTERS-1:0]               HSEL,
    input  logic [2*MASTERS-1:0]             HTRANS,
    input  logic [MASTERS-1:0]               HMASTLOCK,
    input  logic [MASTERS*PRIORITY_BITS-1:0] priority_i,
    input  logic                             HREADY,
    output logic [MASTERS-1:0]               grant_o,
    output logic [MASTERS-1:0]               grant_dp_o,
    output logic [ID_BITS-1:0]               owner_id_o,
    output logic                             locked_o
);

    localparam int c_id_bits   = ID_BITS;
    localparam int c_levels    = $clog2(MASTERS);
    localparam int c_leaves    = 1 << c_levels;
    // tree node layout: {valid, priority, ~rank, index}; the upper part is the sort key
    localparam int c_node_bits = 1 + PRIORITY_BITS + 2 * c_id_bits;

    localparam logic [1:0] c_trans_busy = 2'b01;
    localparam logic [1:0] c_trans_seq  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_HELD   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [MASTERS-1:0]         r_grant;
    logic [MASTERS-1:0]         r_grant_dp;
    logic [c_id_bits-1:0]       r_owner_id;
    logic [c_id_bits-1:0]       r_last_id;

    logic [1:0]                 w_trans [MASTERS];
    logic [PRIORITY_BITS-1:0]   w_prio  [MASTERS];
    logic [c_id_bits-1:0]       w_rank  [MASTERS];
    logic [MASTERS-1:0]         w_req;
    logic [c_id_bits-1:0]       w_start;
    logic                       w_win_valid;
    logic [c_id_bits-1:0]       w_win_idx;
    logic [MASTERS-1:0]         w_win_onehot;
    logic                       w_owned;
    logic [1:0]                 w_own_trans;
    logic                       w_hold;
    logic [MASTERS-1:0]         w_dp_next;

    always_comb begin
        for (int i = 0; i < MASTERS; i++) begin
            w_trans[i] = HTRANS[2*i +: 2];
            w_prio[i]  = priority_i[i*PRIORITY_BITS +: PRIORITY_BITS];
            w_req[i]   = HSEL[i] && (w_trans[i] != 2'b00);
        end
    end

    // Rank 0 is the first master searched after the previous winner
    always_comb begin
        w_start = (r_last_id >= c_id_bits'(MASTERS - 1)) ? '0 : r_last_id + c_id_bits'(1);
        for (int i = 0; i < MASTERS; i++) begin
            if (c_id_bits'(i) >= w_start)
                w_rank[i] = c_id_bits'(i) - w_start;
            else
                w_rank[i] = c_id_bits'(i + MASTERS) - w_start;
        end
    end

    // Balanced comparator tree; ranks are unique so no two valid keys tie
    always_comb begin : p_win_tree
        logic [c_node_bits-1:0] node [2*c_leaves];
        for (int n = 0; n < 2 * c_leaves; n++)
            node[n] = '0;
        for (int j = 0; j < MASTERS; j++)
            node[c_leaves + j] = {w_req[j], w_prio[j], ~w_rank[j], c_id_bits'(j)};
        for (int n = c_leaves - 1; n >= 1; n--) begin
            if (node[2*n+1][c_node_bits-1:c_id_bits] > node[2*n][c_node_bits-1:c_id_bits])
                node[n] = node[2*n+1];
            else
                node[n] = node[2*n];
        end
        w_win_valid = node[1][c_node_bits-1];
        w_win_idx   = node[1][c_id_bits-1:0];
    end

    always_comb begin
        for (int i = 0; i < MASTERS; i++)
            w_win_onehot[i] = (w_win_idx == c_id_bits'(i));
    end

    assign w_owned     = |r_grant;
    assign w_own_trans = w_trans[r_owner_id];
    assign w_hold      = w_owned && HSEL[r_owner_id] &&
                         (w_own_trans == c_trans_busy || w_own_trans == c_trans_seq ||
                          HMASTLOCK[r_owner_id]);
    assign w_dp_next   = (w_owned && HSEL[r_owner_id] && w_own_trans[1]) ? r_grant : '0;

    always_comb begin
        w_state_next = r_state;
        if (HREADY) begin
            if (w_hold)
                w_state_next = HMASTLOCK[r_owner_id] ? ST_LOCKED : ST_HELD;
            else if (w_win_valid)
                w_state_next = HMASTLOCK[w_win_idx] ? ST_LOCKED : ST_OWNED;
            else
                w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant    <= '0;
            r_grant_dp <= '0;
            r_owner_id <= '0;
            r_last_id  <= c_id_bits'(MASTERS - 1);
        end else if (HREADY) begin
            r_grant_dp <= w_dp_next;
            if (!w_hold) begin
                if (w_win_valid) begin
                    r_grant    <= w_win_onehot;
                    r_owner_id <= w_win_idx;
                    r_last_id  <= w_win_idx;
                end else begin
                    r_grant <= '0;
                end
            end
        end
    end

    assign grant_o    = r_grant;
    assign grant_dp_o = r_grant_dp;
    assign owner_id_o = r_owner_id;
    assign locked_o   = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
`default_nettype none
// Bench for ahb3lite_interconnect_slave_arbiter: vector table, lock/reset sequences,
// and random traffic against a behavioural reference model.
module tb_ahb3lite_interconnect_slave_arbiter;

    localparam int M  = 3;
    localparam int PB = 2;

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic [M-1:0]   HSEL;
    logic [2*M-1:0] HTRANS;
    logic [M-1:0]   HMASTLOCK;
    logic [M*PB-1:0] priority_i;
    logic           HREADY;
    logic [M-1:0]   grant_o;
    logic [M-1:0]   grant_dp_o;
    logic [1:0]     owner_id_o;
    logic           locked_o;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: owner / data-phase owner as indices, -1 = none
    int m_own, m_dp, m_last, m_id;
    bit m_lock;

    typedef struct packed {
        logic [2:0] hsel;
        logic [5:0] htrans;
        logic [2:0] lock;
        logic [5:0] prio;
        logic       ready;
        logic [2:0] g;
        logic [2:0] dp;
        logic [1:0] id;
        logic       lk;
    } vec_t;

    vec_t vecs [20];

    always #5 HCLK = ~HCLK;

    ahb3lite_interconnect_slave_arbiter #(.MASTERS(M)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HTRANS     (HTRANS),
        .HMASTLOCK  (HMASTLOCK),
        .priority_i (priority_i),
        .HREADY     (HREADY),
        .grant_o    (grant_o),
        .grant_dp_o (grant_dp_o),
        .owner_id_o (owner_id_o),
        .locked_o   (locked_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit req(input int i);
        return HSEL[i] && (HTRANS[2*i +: 2] != 2'b00);
    endfunction

    function automatic int prio(input int i);
        return int'(priority_i[PB*i +: PB]);
    endfunction

    function automatic int onehot(input int k);
        return (k < 0) ? 0 : (1 << k);
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_dp   = -1;
        m_last = M - 1;
        m_id   = 0;
        m_lock = 1'b0;
    endtask

    // Evaluated with the inputs that will be sampled at the coming edge
    task automatic model_step();
        bit hold;
        int best, w, c;
        if (!HREADY) return;
        hold = (m_own >= 0) && HSEL[m_own] &&
               ((HTRANS[2*m_own +: 2] inside {2'b01, 2'b11}) || HMASTLOCK[m_own]);
        m_dp = (m_own >= 0 && HSEL[m_own] && HTRANS[2*m_own +: 2] >= 2'b10) ? m_own : -1;
        if (hold) begin
            m_lock = HMASTLOCK[m_own];
            return;
        end
        best = -1;
        for (int i = 0; i < M; i++)
            if (req(i) && prio(i) > best) best = prio(i);
        w = -1;
        for (int k = 1; k <= M; k++) begin
            c = (m_last + k) % M;
            if (w < 0 && best >= 0 && req(c) && prio(c) == best) w = c;
        end
        if (w >= 0) begin
            m_own  = w;
            m_last = w;
            m_id   = w;
            m_lock = HMASTLOCK[w];
        end else begin
            m_own  = -1;
            m_lock = 1'b0;
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, " grant_o"},    grant_o,    onehot(m_own));
        check({tag, " grant_dp_o"}, grant_dp_o, onehot(m_dp));
        check({tag, " owner_id_o"}, owner_id_o, m_id);
        check({tag, " locked_o"},   locked_o,   m_lock);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge HCLK);
        #1;
        model_check(tag);
    endtask

    task automatic drive(input logic [2:0] s, input logic [5:0] t, input logic [2:0] l,
                         input logic [5:0] p, input logic r);
        HSEL       = s;
        HTRANS     = t;
        HMASTLOCK  = l;
        priority_i = p;
        HREADY     = r;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // hsel, htrans{m2,m1,m0}, lock, prio{p2,p1,p0}, ready -> grant, dp, id, locked
        vecs[0]  = '{3'b010, 6'b00_10_00, 3'b000, 6'b00_00_00, 1'b1, 3'b010, 3'b000, 2'd1, 1'b0};
        vecs[1]  = '{3'b010, 6'b00_10_00, 3'b000, 6'b00_00_00, 1'b1, 3'b010, 3'b010, 2'd1, 1'b0};
        vecs[2]  = '{3'b000, 6'b00_00_00, 3'b000, 6'b00_00_00, 1'b1, 3'b000, 3'b000, 2'd1, 1'b0};
        vecs[3]  = '{3'b101, 6'b10_00_10, 3'b000, 6'b01_00_10, 1'b1, 3'b001, 3'b000, 2'd0, 1'b0};
        vecs[4]  = '{3'b101, 6'b10_00_00, 3'b000, 6'b01_00_10, 1'b1, 3'b100, 3'b000, 2'd2, 1'b0};
        vecs[5]  = '{3'b000, 6'b00_00_00, 3'b000, 6'b00_00_00, 1'b1, 3'b000, 3'b000, 2'd2, 1'b0};
        vecs[6]  = '{3'b111, 6'b10_10_10, 3'b000, 6'b00_00_00, 1'b1, 3'b001, 3'b000, 2'd0, 1'b0};
        vecs[7]  = '{3'b111, 6'b10_10_10, 3'b000, 6'b00_00_00, 1'b1, 3'b010, 3'b001, 2'd1, 1'b0};
        vecs[8]  = '{3'b111, 6'b10_10_10, 3'b000, 6'b00_00_00, 1'b1, 3'b100, 3'b010, 2'd2, 1'b0};
        vecs[9]  = '{3'b111, 6'b10_10_10, 3'b000, 6'b00_00_00, 1'b1, 3'b001, 3'b100, 2'd0, 1'b0};
        vecs[10] = '{3'b000, 6'b00_00_00, 3'b000, 6'b00_00_00, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0};
        vecs[11] = '{3'b010, 6'b00_10_00, 3'b000, 6'b10_01_00, 1'b1, 3'b010, 3'b000, 2'd1, 1'b0};
        vecs[12] = '{3'b010, 6'b00_10_00, 3'b000, 6'b10_01_00, 1'b1, 3'b010, 3'b010, 2'd1, 1'b0};
        vecs[13] = '{3'b110, 6'b10_11_00, 3'b000, 6'b10_01_00, 1'b1, 3'b010, 3'b010, 2'd1, 1'b0};
        vecs[14] = '{3'b110, 6'b10_11_00, 3'b000, 6'b10_01_00, 1'b0, 3'b010, 3'b010, 2'd1, 1'b0};
        vecs[15] = '{3'b110, 6'b10_11_00, 3'b000, 6'b10_01_00, 1'b0, 3'b010, 3'b010, 2'd1, 1'b0};
        vecs[16] = '{3'b110, 6'b10_11_00, 3'b000, 6'b10_01_00, 1'b1, 3'b010, 3'b010, 2'd1, 1'b0};
        vecs[17] = '{3'b110, 6'b10_11_00, 3'b000, 6'b10_01_00, 1'b1, 3'b010, 3'b010, 2'd1, 1'b0};
        vecs[18] = '{3'b110, 6'b10_00_00, 3'b000, 6'b10_01_00, 1'b1, 3'b100, 3'b000, 2'd2, 1'b0};
        vecs[19] = '{3'b000, 6'b00_00_00, 3'b000, 6'b00_00_00, 1'b1, 3'b000, 3'b000, 2'd2, 1'b0};

        model_reset();
        HRESETn = 1'b0;
        drive(3'b000, 6'b0, 3'b000, 6'b0, 1'b1);
        repeat (2) @(posedge HCLK);
        #1;
        check("reset grant_o",    grant_o,    0);
        check("reset grant_dp_o", grant_dp_o, 0);
        check("reset owner_id_o", owner_id_o, 0);
        check("reset locked_o",   locked_o,   0);
        #1 HRESETn = 1'b1;

        for (int r = 0; r < 20; r++) begin
            drive(vecs[r].hsel, vecs[r].htrans, vecs[r].lock, vecs[r].prio, vecs[r].ready);
            tick($sformatf("vec%0d model", r));
            check($sformatf("vec%0d grant_o", r),    grant_o,    vecs[r].g);
            check($sformatf("vec%0d grant_dp_o", r), grant_dp_o, vecs[r].dp);
            check($sformatf("vec%0d owner_id_o", r), owner_id_o, vecs[r].id);
            check($sformatf("vec%0d locked_o", r),   locked_o,   vecs[r].lk);
        end

        // Locked sequence: master 0 NONSEQ, NONSEQ, IDLE under lock; master 1 waits
        drive(3'b011, 6'b00_10_10, 3'b001, 6'b0, 1'b1);
        tick("lock1");
        check("lock1 grant_o", grant_o, 3'b001);
        check("lock1 locked_o", locked_o, 1);
        tick("lock2");
        check("lock2 grant_o", grant_o, 3'b001);
        check("lock2 locked_o", locked_o, 1);
        drive(3'b011, 6'b00_10_00, 3'b001, 6'b0, 1'b1);
        tick("lock3");
        check("lock3 grant_o", grant_o, 3'b001);
        check("lock3 locked_o", locked_o, 1);
        drive(3'b010, 6'b00_10_00, 3'b000, 6'b0, 1'b1);
        tick("unlock");
        check("unlock grant_o", grant_o, 3'b010);
        check("unlock locked_o", locked_o, 0);
        tick("m1 dp");
        check("m1 dp grant_dp_o", grant_dp_o, 3'b010);

        // Asynchronous reset in the middle of a cycle
        #2 HRESETn = 1'b0;
        model_reset();
        #1;
        check("async grant_o",    grant_o,    0);
        check("async grant_dp_o", grant_dp_o, 0);
        check("async owner_id_o", owner_id_o, 0);
        check("async locked_o",   locked_o,   0);
        drive(3'b111, 6'b10_10_10, 3'b000, 6'b0, 1'b1);
        #2 HRESETn = 1'b1;
        tick("post-reset");
        check("post-reset grant_o", grant_o, 3'b001);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] lk;
            lk = '0;
            for (int i = 0; i < M; i++)
                lk[i] = ($urandom_range(0, 7) == 0);
            drive(3'($urandom), 6'($urandom), lk,
                  ($urandom_range(0, 15) == 0) ? 6'($urandom) : priority_i,
                  ($urandom_range(0, 3) != 0));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb3lite_interconnect_slave_arbiter.md
# ahb3lite_interconnect_slave_arbiter

Per-slave-port arbiter for the AHB3-Lite interconnect matrix. It decides which master owns the address phase of one slave port. Selection is by highest programmed priority, with round-robin tie-break among masters of equal priority. It sequences ownership hand-over on HREADY boundaries, holds the bus for bursts and locked transfers, and tracks the data-phase owner so the slave-side mux steers HWDATA/HRDATA correctly.

## Interface
- MASTERS, 3, number of master ports competing for this slave (≥1)
- PRIORITY_BITS, MASTERS==1 ? 1 : $clog2(MASTERS), priority width per master (treat as localparam)

Clocking: one clock; reset is asynchronous and active-low (HCLK, HRESETn).

- HCLK  input  1  system clock, all state updates on rising edge
- HRESETn  input  1  asynchronous active-low reset
- HSEL  input  MASTERS  per-master select of this slave (request)
- HTRANS  input  MASTERS×2  per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- HMASTLOCK  input  MASTERS  per-master lock
- priority_i  input  MASTERS×PRIORITY_BITS  per-master priority, unsigned, larger wins
- HREADY  input  1  slave HREADYOUT (transfer-phase completion)
- grant_o  output  MASTERS  one-hot address-phase owner, all-zero = no owner
- grant_dp_o  output  MASTERS  one-hot data-phase owner, all-zero = no data phase
- owner_id_o  output  max(1,$clog2(MASTERS))  binary index of grant_o, holds last owner when grant_o=0
- locked_o  output  1  current ownership is held by HMASTLOCK

## Operation
- req[i] = HSEL[i] & (HTRANS[i] != IDLE).
- hold = grant_o≠0 & HSEL[own] & (HTRANS[own]∈{BUSY,SEQ} | HMASTLOCK[own]).
- Arbitration event: rising HCLK with HREADY=1 and hold=0.
  - Winner = requester with maximum priority_i.
  - Ties are resolved round-robin, starting at index (last_id+1) mod MASTERS, searching upward with wrap.
- On arbitration event: grant_o <= one-hot(winner), or 0 if no req.
  - last_id <= winner when a winner exists, otherwise unchanged.
- The current owner competes like any other master. A NONSEQ from the owner while another master of equal priority requests therefore hands over (fairness).
- States: IDLE (grant_o=0), OWNED (grant_o≠0, hold=0), HELD (hold=1, burst), LOCKED (hold via HMASTLOCK; locked_o=1).
  - IDLE→OWNED/HELD/LOCKED on arbitration with a winner.
  - HELD/LOCKED→OWNED when hold drops.
  - Any state→IDLE on arbitration event with no req.
- Data phase: on rising HCLK with HREADY=1:
  - grant_dp_o <= grant_o when the owner's HTRANS∈{NONSEQ,SEQ} and its HSEL=1;
  - otherwise grant_dp_o <= 0.
- HREADY=0: grant_o, grant_dp_o, last_id and state all hold, regardless of req changes.
- Owner drops HSEL mid-burst: hold=0, so a normal arbitration event occurs at the next HREADY=1 edge.
- MASTERS=1: grant_o[0] follows req[0] at arbitration events; round-robin is a no-op.
- Priority changes take effect only at the next arbitration event.

## Timing
- Reset values: grant_o=0, grant_dp_o=0, owner_id_o=0, locked_o=0. last_id=MASTERS-1, so master 0 wins the first tie.
- Reset is asynchronous mid-transfer: all outputs clear immediately, with no glitch-free hand-over requirement.
- Grant latency is 1 cycle. req asserted in cycle N with HREADY=1 gives grant_o valid in N+1. Non-granted masters are stalled by the interconnect.
- grant_dp_o lags grant_o by exactly one HREADY=1 edge.
- All outputs are registered, with no combinational path from inputs to outputs. owner_id_o and locked_o are derived from registers only.
- Winner search is a combinational tree of depth ⌈log2 MASTERS⌉ comparators. It must meet single-cycle timing at MASTERS=16.

## Test plan
- Reset then single request:
  - Stimulus: HRESETn low→high; HSEL=3'b010, HTRANS[1]=NONSEQ, HREADY=1.
  - Required: next cycle grant_o=3'b010, owner_id_o=1. Following cycle grant_dp_o=3'b010.
- Priority win:
  - Stimulus: masters 0,2 request NONSEQ; priority_i={2:1, 0:2}.
  - Required: grant_o=3'b001.
  - Then master 0 goes IDLE: grant_o=3'b100 after the next HREADY=1 edge.
- Round-robin tie:
  - Stimulus: all three request NONSEQ continuously with equal priority, HREADY=1.
  - Required: grant_o sequence 001,010,100,001.
- Burst hold and HREADY stall:
  - Stimulus: master 1 owns with SEQ×3 while master 2 (higher priority) requests; HREADY=0 for 2 cycles mid-burst.
  - Required: grant_o stays 010 through the stall and burst. Master 2 is granted one cycle after master 1's last SEQ completes with HREADY=1.
- Lock:
  - Stimulus: master 0 asserts HMASTLOCK across NONSEQ,NONSEQ,IDLE; master 1 requests throughout.
  - Required: locked_o=1 and grant_o=001 until HMASTLOCK drops, then grant_o=010.
- Async reset mid-burst:
  - Stimulus: HRESETn low while grant_o=010, grant_dp_o=010.
  - Required: all outputs 0 in the same cycle. After release with all requesting and equal priority, master 0 is granted first.
